// File: rtl/cfg_pkg.sv
// cfg_pkg: shared states, default sizes and frame type for the configuration frame loader.
package cfg_pkg;
  localparam int FRAME_W_DEF = 77;
  localparam int NUM_FRAMES_DEF = 16;
  typedef enum logic [1:0] {LOAD, CHECK, DONE, ERR} state_t;
  typedef logic [FRAME_W_DEF-1:0] frame_t;
endpackage

// File: rtl/cfg_frame_store.sv
// cfg_frame_store: frame array with one write port, a registered read port and a flat view for the fabric.
module cfg_frame_store #(
  parameter int FRAME_W = 77,
  parameter int NUM_FRAMES = 16,
  parameter int AW = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [FRAME_W-1:0]            wdata,
  input  logic [AW-1:0]                 rd_addr,
  output logic [FRAME_W-1:0]            rd_data,
  output logic [NUM_FRAMES*FRAME_W-1:0] flat
);
  logic [NUM_FRAMES-1:0][FRAME_W-1:0] mem;
  assign flat = mem;
  // Read samples mem before this edge's write lands, so a colliding read returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
      rd_data <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: loads configuration frames, verifies an XOR checksum and exposes the result to the fabric.
module cfg_frame_loader
  import cfg_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int NUM_FRAMES = NUM_FRAMES_DEF,
  parameter int CHECK_EN = 1,
  localparam int CW = $clog2(NUM_FRAMES + 1),
  localparam int AW = $clog2(NUM_FRAMES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FRAME_W-1:0]            bit_i,
  input  logic                          bit_v_i,
  output logic                          bit_r_o,
  input  logic                          reconfig_i,
  output logic                          done_o,
  output logic                          err_o,
  output logic [CW-1:0]                 cnt_o,
  output logic [NUM_FRAMES*FRAME_W-1:0] cfg_o,
  input  logic [AW-1:0]                 rd_addr_i,
  output logic [FRAME_W-1:0]            rd_data_o
);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [FRAME_W-1:0] acc;
  logic [NUM_FRAMES*FRAME_W-1:0] flat;
  logic ld, chk;
  assign ld = bit_v_i && !reconfig_i && state == LOAD;
  assign chk = bit_v_i && !reconfig_i && state == CHECK;
  assign cnt_o = cnt;
  assign cfg_o = done_o ? flat : '0;
  always_comb begin
    nxt = reconfig_i ? LOAD
        : (ld && cnt == CW'(NUM_FRAMES - 1)) ? (CHECK_EN != 0 ? CHECK : DONE)
        : chk ? (bit_i == acc ? DONE : ERR)
        : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt <= '0;
      acc <= '0;
      bit_r_o <= 1'b1;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= nxt;
      bit_r_o <= nxt == LOAD || nxt == CHECK;
      done_o <= nxt == DONE;
      err_o <= nxt == ERR;
      if (reconfig_i) begin
        cnt <= '0;
        acc <= '0;
      end else if (ld) begin
        cnt <= cnt == CW'(NUM_FRAMES) ? cnt : cnt + 1'b1;
        acc <= acc ^ bit_i;
      end
    end
  end
  cfg_frame_store #(.FRAME_W(FRAME_W), .NUM_FRAMES(NUM_FRAMES), .AW(AW)) u_store (
    .clk(clk),
    .rst(rst),
    .we(ld),
    .waddr(cnt[AW-1:0]),
    .wdata(bit_i),
    .rd_addr(rd_addr_i),
    .rd_data(rd_data_o),
    .flat(flat)
  );
endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb_cfg_frame_loader: directed/randomized bench for cfg_frame_loader with a frame-list reference model.
module tb_cfg_frame_loader;
  import cfg_pkg::*;
  logic clk = 1'b0;
  logic rst, bit_v, reconfig, bit_r, done, err;
  frame_t bit_i, rd_data;
  logic [4:0] cnt;
  logic [16*77-1:0] cfg;
  logic [3:0] rd_addr;
  logic [7:0] s_bit, s_rd;
  logic s_v, s_rc, s_r, s_done, s_err;
  logic [2:0] s_cnt;
  logic [31:0] s_cfg;
  logic [1:0] s_addr;
  int checks = 0;
  int failures = 0;
  frame_t fr[16];
  frame_t exp_store[16];
  frame_t cs;
  always #5 clk = ~clk;
  cfg_frame_loader dut (
    .clk(clk), .rst(rst), .bit_i(bit_i), .bit_v_i(bit_v), .bit_r_o(bit_r),
    .reconfig_i(reconfig), .done_o(done), .err_o(err), .cnt_o(cnt), .cfg_o(cfg),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data)
  );
  cfg_frame_loader #(.FRAME_W(8), .NUM_FRAMES(4), .CHECK_EN(0)) dut_s (
    .clk(clk), .rst(rst), .bit_i(s_bit), .bit_v_i(s_v), .bit_r_o(s_r),
    .reconfig_i(s_rc), .done_o(s_done), .err_o(s_err), .cnt_o(s_cnt), .cfg_o(s_cfg),
    .rd_addr_i(s_addr), .rd_data_o(s_rd)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic frame_t rnd();
    return frame_t'({$urandom, $urandom, $urandom});
  endfunction
  function automatic frame_t xor_all();
    frame_t x = '0;
    for (int i = 0; i < 16; i++) x ^= fr[i];
    return x;
  endfunction
  task automatic cyc(input logic v, input frame_t d, input logic rc);
    bit_v = v;
    bit_i = d;
    reconfig = rc;
    @(negedge clk);
  endtask
  task automatic new_frames();
    for (int i = 0; i < 16; i++) fr[i] = rnd();
  endtask
  task automatic load_all();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, fr[i], 1'b0);
      exp_store[i] = fr[i];
      if (i % 4 == 3) repeat (5) cyc(1'b0, rnd(), 1'b0);
    end
  endtask
  task automatic check_cfg(input string tag, input bit shown);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s[%0d]", tag, k), 128'(cfg[k*77 +: 77]), shown ? 128'(exp_store[k]) : 128'd0);
  endtask
  task automatic sweep(input string tag, input bit zero);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, a), 128'(rd_data), zero ? 128'd0 : 128'(exp_store[a]));
    end
  endtask
  initial begin
    logic [7:0] sf[4];
    sf[0] = 8'hA5; sf[1] = 8'h3C; sf[2] = 8'hFF; sf[3] = 8'h01;
    rst = 1'b1; bit_v = 1'b0; bit_i = '0; reconfig = 1'b0; rd_addr = '0;
    s_bit = '0; s_v = 1'b0; s_rc = 1'b0; s_addr = '0;
    for (int i = 0; i < 16; i++) exp_store[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    check_cfg("rst_cfg", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 128'(bit_r), 128'd1);
    chk("rel_cnt", 128'(cnt), 128'd0);
    chk("rel_rd", 128'(rd_data), 128'd0);
    // Small instance without checksum: completes right after the last data frame.
    for (int i = 0; i < 4; i++) begin
      s_v = 1'b1;
      s_bit = sf[i];
      @(negedge clk);
      if (i < 3) chk("s_not_done", 128'(s_done), 128'd0);
    end
    s_v = 1'b0;
    chk("s_done", 128'(s_done), 128'd1);
    chk("s_err", 128'(s_err), 128'd0);
    chk("s_ready", 128'(s_r), 128'd0);
    chk("s_cfg", 128'(s_cfg), 128'h01FF3CA5);
    chk("s_cnt", 128'(s_cnt), 128'd4);
    new_frames();
    load_all();
    chk("pre_cs_done", 128'(done), 128'd0);
    chk("pre_cs_ready", 128'(bit_r), 128'd1);
    cyc(1'b1, xor_all(), 1'b0);
    chk("ok_done", 128'(done), 128'd1);
    chk("ok_err", 128'(err), 128'd0);
    chk("ok_ready", 128'(bit_r), 128'd0);
    chk("ok_cnt", 128'(cnt), 128'd16);
    check_cfg("ok_cfg", 1'b1);
    repeat (40) cyc(1'b1, rnd(), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("hold_cnt", 128'(cnt), 128'd16);
    chk("hold_done", 128'(done), 128'd1);
    check_cfg("hold_cfg", 1'b1);
    sweep("rb", 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("rc_cnt", 128'(cnt), 128'd0);
    chk("rc_ready", 128'(bit_r), 128'd1);
    chk("rc_done", 128'(done), 128'd0);
    check_cfg("rc_cfg", 1'b0);
    new_frames();
    load_all();
    cs = xor_all() ^ frame_t'(1);
    cyc(1'b1, cs, 1'b0);
    chk("bad_err", 128'(err), 128'd1);
    chk("bad_done", 128'(done), 128'd0);
    chk("bad_ready", 128'(bit_r), 128'd0);
    check_cfg("bad_cfg", 1'b0);
    cyc(1'b1, xor_all(), 1'b0);
    chk("bad_hold_err", 128'(err), 128'd1);
    cyc(1'b0, '0, 1'b1);
    new_frames();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, fr[i], 1'b0);
      exp_store[i] = fr[i];
    end
    chk("ab_cnt8", 128'(cnt), 128'd8);
    cyc(1'b1, fr[8], 1'b1);
    bit_v = 1'b0;
    reconfig = 1'b0;
    chk("ab_cnt", 128'(cnt), 128'd0);
    chk("ab_ready", 128'(bit_r), 128'd1);
    rd_addr = 4'd8;
    @(negedge clk);
    chk("ab_f8_kept", 128'(rd_data), 128'(exp_store[8]));
    new_frames();
    load_all();
    cyc(1'b1, xor_all(), 1'b0);
    chk("re_done", 128'(done), 128'd1);
    chk("re_err", 128'(err), 128'd0);
    check_cfg("re_cfg", 1'b1);
    sweep("re_rb", 1'b0);
    cyc(1'b0, '0, 1'b1);
    new_frames();
    for (int i = 0; i < 5; i++) cyc(1'b1, fr[i], 1'b0);
    bit_v = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_cnt", 128'(cnt), 128'd0);
    chk("mrst_done", 128'(done), 128'd0);
    chk("mrst_ready", 128'(bit_r), 128'd1);
    check_cfg("mrst_cfg", 1'b0);
    sweep("mrst_rb", 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cfg_frame_loader.md
CFG_FRAME_LOADER -- requirements
Module: cfg_frame_loader

Interface
REQ-001 SHALL have parameter FRAME_W, default 77: configuration frame width in bits.
REQ-002 SHALL have parameter NUM_FRAMES, default 16: number of data frames per bitstream, minimum 2.
REQ-003 SHALL have parameter CHECK_EN, default 1: 1 = a trailing XOR checksum frame is required; 0 = no checksum frame.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock), then rst input 1 (synchronous, active-high reset).
REQ-005 bit_i  input  FRAME_W  frame data.
REQ-006 bit_v_i  input  1  frame valid.
REQ-007 bit_r_o  output  1  loader ready; a frame is accepted on a cycle where bit_v_i && bit_r_o.
REQ-008 reconfig_i  input  1  single-cycle request to restart loading.
REQ-009 done_o  output  1  configuration complete and checksum passed.
REQ-010 err_o  output  1  checksum mismatch.
REQ-011 cnt_o  output  clog2(NUM_FRAMES+1)  number of data frames accepted so far.
REQ-012 cfg_o  output  NUM_FRAMES*FRAME_W  configuration bus to fabric; frame k occupies bits [k*FRAME_W +: FRAME_W].
REQ-013 rd_addr_i  input  clog2(NUM_FRAMES)  readback frame address.
REQ-014 rd_data_o  output  FRAME_W  readback data.

Function
REQ-015 States SHALL be LOAD, CHECK, DONE and ERR.
REQ-016 In LOAD, bit_r_o SHALL be 1; each accepted frame SHALL be written to store[cnt]; cnt SHALL increment; the running XOR SHALL be updated with the frame.
REQ-017 On acceptance of data frame NUM_FRAMES-1, the next state SHALL be CHECK if CHECK_EN=1, else DONE.
REQ-018 In CHECK, bit_r_o SHALL be 1; one accepted frame SHALL be compared with the running XOR, without being stored.
  - equal: next state DONE.
  - unequal: next state ERR.
REQ-019 In DONE and ERR, bit_r_o SHALL be 0; bit_v_i SHALL be ignored.
REQ-020 done_o SHALL equal (state==DONE); err_o SHALL equal (state==ERR); both SHALL be registered state decodes.
REQ-021 cfg_o SHALL present the store contents only in DONE, and SHALL be all zeros in every other state, so the fabric never sees a partial configuration.
REQ-022 reconfig_i in any state SHALL, on the next edge:
  - enter LOAD;
  - clear cnt and the running XOR;
  - leave store contents unchanged until overwritten.
REQ-023 reconfig_i coincident with an accepted frame SHALL take precedence; that frame SHALL be discarded.
REQ-024 Gaps in bit_v_i SHALL be tolerated indefinitely in LOAD and CHECK, with no timeout.
REQ-025 rd_data_o SHALL equal store[rd_addr_i] one cycle after rd_addr_i is applied, in all states.
REQ-026 A write to the addressed frame in the same cycle as a read SHALL return the old data.
REQ-027 cnt_o SHALL saturate at NUM_FRAMES; it SHALL NOT wrap.

Reset
REQ-028 While rst=1 at a clk edge, the block SHALL set:
  - state = LOAD;
  - cnt = 0 and running XOR = 0;
  - all store frames = 0;
  - rd_data_o = 0.
REQ-029 During reset, outputs SHALL be: bit_r_o=1 one cycle after release, done_o=0, err_o=0, cfg_o=0.
REQ-030 rst asserted mid-load SHALL abort the load with no partial state retained.

Structure
REQ-031 Package cfg_pkg SHALL hold:
  - the state enum;
  - default FRAME_W / NUM_FRAMES constants;
  - a frame_t typedef.
REQ-032 The frame array with write port and registered read port SHALL be a sub-module, cfg_frame_store.
REQ-033 The FSM, counter and XOR accumulator SHALL reside in cfg_frame_loader.

Verification
REQ-034 Happy path: defaults, 16 frames in bursts of 4 with 5-cycle gaps, then checksum = XOR of the 16 frames.
  - Required response: done_o=1 on the cycle after the checksum is accepted, bit_r_o=0, cfg_o == concatenated frames.
REQ-035 Bad checksum: same 16 frames, then checksum XOR 77'h1.
  - Required response: err_o=1, done_o=0, cfg_o=0, bit_r_o=0.
REQ-036 Abort: reconfig_i pulsed after frame 7, coincident with frame 8.
  - Required response: frame 8 not stored; cnt_o=0 next cycle.
  - Then a full reload of 16 frames plus checksum: done_o=1.
REQ-037 Readback: after DONE, sweep rd_addr_i 0..15.
  - Required response: rd_data_o matches each written frame with 1-cycle latency.
  - Then rst: all reads return 0.
REQ-038 CHECK_EN=0, NUM_FRAMES=4, FRAME_W=8: frames 8'hA5, 8'h3C, 8'hFF, 8'h01.
  - Required response: done_o=1 directly after frame 3; cfg_o=32'h01FF3CA5.
REQ-039 Hold-off: bit_v_i=1 held for 40 cycles after DONE.
  - Required response: no store change, cnt_o stays 16, done_o stays 1.
